// File: rtl/alu_seq_ctrl.sv
// ---------------------------------------------------------------------------
// alu_seq_ctrl
//
// Operand-entry sequencer with a registered ALU for the board-level
// calculator. Button pulses walk the user through OP1 -> OP2 -> OPCODE ->
// RESULT, latching switch data at each stage. The commit in the OPCODE stage
// computes and registers result, flags and the error bit in one edge. A chain
// option feeds the last result back in as the next operand 1.
//
// Ports:
//   CLK100MHZ    in   1      system clock, 100 MHz
//   CPU_RESETN   in   1      asynchronous active-low reset
//   enter_p      in   1      one-cycle pulse: advance / commit
//   back_p       in   1      one-cycle pulse: step back one stage
//   chain        in   1      level: on enter in RESULT, result becomes op1
//   signed_mode  in   1      level: error source, 1 = V, 0 = C
//   sw           in   WIDTH  switch data for operand / opcode entry
//   op1          out  WIDTH  latched operand 1
//   op2          out  WIDTH  latched operand 2
//   opcode       out  OPW    latched opcode
//   result       out  WIDTH  registered ALU result
//   flags        out  4      {N,Z,C,V}, registered with result
//   err          out  1      registered error flag
//   res_valid    out  1      high while result/flags are valid
//   state        out  2      0=OP1, 1=OP2, 2=OPC, 3=RES
// ---------------------------------------------------------------------------
module alu_seq_ctrl #(
    parameter int WIDTH = 16,
    parameter int OPW   = 3,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             CLK100MHZ,
    input  logic             CPU_RESETN,
    input  logic             enter_p,
    input  logic             back_p,
    input  logic             chain,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] sw,
    output logic [WIDTH-1:0] op1,
    output logic [WIDTH-1:0] op2,
    output logic [OPW-1:0]   opcode,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             err,
    output logic             res_valid,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        ST_OP1 = 2'd0,
        ST_OP2 = 2'd1,
        ST_OPC = 2'd2,
        ST_RES = 2'd3
    } state_e;

    // -----------------------------------------------------------------------
    // Reset synchroniser: assertion is immediate, release is aligned to the
    // clock two edges later so no flop sees a reset edge near the clock.
    // -----------------------------------------------------------------------
    logic [1:0] rst_sync_q;
    logic       rst_n_int;

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n_int = rst_sync_q[1];

    // -----------------------------------------------------------------------
    // State and data registers
    // -----------------------------------------------------------------------
    state_e           state_q;
    logic [WIDTH-1:0] op1_q;
    logic [WIDTH-1:0] op2_q;
    logic [OPW-1:0]   opcode_q;
    logic [WIDTH-1:0] result_q;
    logic [3:0]       flags_q;
    logic             err_q;
    logic             res_valid_q;

    // -----------------------------------------------------------------------
    // ALU: evaluated from the latched operands and the opcode currently on
    // the switches; only captured into result_q at the commit edge.
    // -----------------------------------------------------------------------
    logic [OPW-1:0]   opc_d;
    logic             opc_undef;
    logic [SHW-1:0]   sh_amt;
    logic [WIDTH:0]   add_full;
    logic [WIDTH-1:0] sub_res;
    logic [WIDTH:0]   shl_full;
    logic [WIDTH-1:0] result_d;
    logic             c_d;
    logic             v_d;
    logic [3:0]       flags_d;
    logic             err_d;

    // Signed overflow for add/sub from the sign bits of a, b and the result.
    // A subtract behaves like an add of -b, so b's sign is inverted.
    function automatic logic ovf(input logic a_msb, input logic b_msb,
                                 input logic r_msb, input logic is_sub);
        return (a_msb == (b_msb ^ is_sub)) && (r_msb != a_msb);
    endfunction

    assign opc_d  = sw[OPW-1:0];
    assign sh_amt = op2_q[SHW-1:0];

    // Opcodes beyond 7 only exist when the opcode field is wider than 3 bits.
    generate
        if (OPW > 3) begin : g_wide_opc
            assign opc_undef = |opc_d[OPW-1:3];
        end else begin : g_narrow_opc
            assign opc_undef = 1'b0;
        end
    endgenerate

    assign add_full = {1'b0, op1_q} + {1'b0, op2_q};
    assign sub_res  = op1_q - op2_q;
    // One extra MSB catches the last bit shifted out; it is 0 for a zero
    // shift and for shifts longer than the word.
    assign shl_full = {1'b0, op1_q} << sh_amt;

    always_comb begin
        result_d = '0;
        c_d      = 1'b0;
        v_d      = 1'b0;
        if (!opc_undef) begin
            case (opc_d[2:0])
                3'd0: begin
                    result_d = add_full[WIDTH-1:0];
                    c_d      = add_full[WIDTH];
                    v_d      = ovf(op1_q[WIDTH-1], op2_q[WIDTH-1],
                                   add_full[WIDTH-1], 1'b0);
                end
                3'd1: begin
                    result_d = sub_res;
                    c_d      = (op1_q < op2_q);
                    v_d      = ovf(op1_q[WIDTH-1], op2_q[WIDTH-1],
                                   sub_res[WIDTH-1], 1'b1);
                end
                3'd2: result_d = op1_q | op2_q;
                3'd3: result_d = op1_q & op2_q;
                3'd4: result_d = op1_q ^ op2_q;
                3'd5: begin
                    result_d = shl_full[WIDTH-1:0];
                    c_d      = shl_full[WIDTH];
                end
                3'd6: result_d = op1_q >> sh_amt;
                default: result_d = op1_q;
            endcase
        end
    end

    assign flags_d = {result_d[WIDTH-1], (result_d == '0), c_d, v_d};
    assign err_d   = opc_undef ? 1'b1 : (signed_mode ? v_d : c_d);

    // -----------------------------------------------------------------------
    // Sequencer. back_p has priority over enter_p in every state.
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK100MHZ or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state_q     <= ST_OP1;
            op1_q       <= '0;
            op2_q       <= '0;
            opcode_q    <= '0;
            result_q    <= '0;
            flags_q     <= '0;
            err_q       <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_OP1: begin
                    if (enter_p && !back_p) begin
                        op1_q   <= sw;
                        state_q <= ST_OP2;
                    end
                end
                ST_OP2: begin
                    if (back_p) begin
                        state_q <= ST_OP1;
                    end else if (enter_p) begin
                        op2_q   <= sw;
                        state_q <= ST_OPC;
                    end
                end
                ST_OPC: begin
                    if (back_p) begin
                        state_q <= ST_OP2;
                    end else if (enter_p) begin
                        opcode_q    <= opc_d;
                        result_q    <= result_d;
                        flags_q     <= flags_d;
                        err_q       <= err_d;
                        res_valid_q <= 1'b1;
                        state_q     <= ST_RES;
                    end
                end
                ST_RES: begin
                    if (back_p || enter_p) begin
                        // Any exit from RES invalidates the displayed result.
                        res_valid_q <= 1'b0;
                        result_q    <= '0;
                        flags_q     <= '0;
                        err_q       <= 1'b0;
                        if (back_p) begin
                            state_q <= ST_OPC;
                        end else if (chain) begin
                            op1_q   <= result_q;
                            op2_q   <= '0;
                            state_q <= ST_OP2;
                        end else begin
                            op1_q    <= '0;
                            op2_q    <= '0;
                            opcode_q <= '0;
                            state_q  <= ST_OP1;
                        end
                    end
                end
                default: state_q <= ST_OP1;
            endcase
        end
    end

    assign op1       = op1_q;
    assign op2       = op2_q;
    assign opcode    = opcode_q;
    assign result    = result_q;
    assign flags     = flags_q;
    assign err       = err_q;
    assign res_valid = res_valid_q;
    assign state     = state_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_seq_ctrl
//
// Directed testbench for alu_seq_ctrl at WIDTH=16, OPW=3. Each task drives
// one scenario and checks outputs against hand-computed values. Inputs change
// and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_alu_seq_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic        enter_p;
    logic        back_p;
    logic        chain;
    logic        signed_mode;
    logic [15:0] sw;
    logic [15:0] op1;
    logic [15:0] op2;
    logic [2:0]  opcode;
    logic [15:0] result;
    logic [3:0]  flags;
    logic        err;
    logic        res_valid;
    logic [1:0]  state;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_seq_ctrl #(.WIDTH(16), .OPW(3)) dut (
        .CLK100MHZ  (clk),
        .CPU_RESETN (rstn),
        .enter_p    (enter_p),
        .back_p     (back_p),
        .chain      (chain),
        .signed_mode(signed_mode),
        .sw         (sw),
        .op1        (op1),
        .op2        (op2),
        .opcode     (opcode),
        .result     (result),
        .flags      (flags),
        .err        (err),
        .res_valid  (res_valid),
        .state      (state)
    );

    // One-cycle pulse of enter/back with sw set; returns on the next falling
    // edge, after the capturing rising edge.
    task automatic press(input logic e, input logic b, input logic [15:0] v);
        @(negedge clk);
        sw      = v;
        enter_p = e;
        back_p  = b;
        @(negedge clk);
        enter_p = 1'b0;
        back_p  = 1'b0;
    endtask

    task automatic enter_seq(input logic [15:0] a, input logic [15:0] b,
                             input logic [15:0] opc);
        press(1'b1, 1'b0, a);
        press(1'b1, 1'b0, b);
        press(1'b1, 1'b0, opc);
    endtask

    task automatic clear_to_op1();
        chain = 1'b0;
        press(1'b1, 1'b0, 16'h0000);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rstn = 1'b0; enter_p = 1'b0; back_p = 1'b0; chain = 1'b0;
        signed_mode = 1'b0; sw = 16'h0000;
        repeat (3) @(negedge clk);
        checks++; if (state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
        checks++; if (op1 !== 16'h0 || op2 !== 16'h0 || opcode !== 3'd0) begin failures++; $display("FAIL reset_ops got=%h/%h/%h exp=0/0/0", op1, op2, opcode); end
        checks++; if (result !== 16'h0 || flags !== 4'h0 || err !== 1'b0 || res_valid !== 1'b0) begin failures++; $display("FAIL reset_res got=%h/%b/%b/%b exp=0", result, flags, err, res_valid); end
        release_reset();
    endtask

    task automatic test_add_basic();
        press(1'b1, 1'b0, 16'h0005);
        checks++; if (state !== 2'd1 || op1 !== 16'h0005) begin failures++; $display("FAIL add_op1 got=%0d/%h exp=1/0005", state, op1); end
        press(1'b1, 1'b0, 16'h0003);
        checks++; if (state !== 2'd2 || op2 !== 16'h0003 || res_valid !== 1'b0) begin failures++; $display("FAIL add_op2 got=%0d/%h/%b exp=2/0003/0", state, op2, res_valid); end
        press(1'b1, 1'b0, 16'h0000);
        checks++; if (state !== 2'd3 || res_valid !== 1'b1) begin failures++; $display("FAIL add_commit got=%0d/%b exp=3/1", state, res_valid); end
        checks++; if (result !== 16'h0008 || flags !== 4'b0000 || err !== 1'b0) begin failures++; $display("FAIL add_result got=%h/%b/%b exp=0008/0000/0", result, flags, err); end
        clear_to_op1();
        checks++; if (state !== 2'd0 || op1 !== 16'h0 || op2 !== 16'h0 || result !== 16'h0 || res_valid !== 1'b0) begin failures++; $display("FAIL clear got=%0d/%h/%h/%h/%b exp=0/0/0/0/0", state, op1, op2, result, res_valid); end
    endtask

    task automatic test_add_carry();
        signed_mode = 1'b0;
        enter_seq(16'hFFFF, 16'h0001, 16'h0000);
        checks++; if (result !== 16'h0000 || flags !== 4'b0110 || err !== 1'b1) begin failures++; $display("FAIL carry_c got=%h/%b/%b exp=0000/0110/1", result, flags, err); end
        // err holds its commit-time value while signed_mode moves
        signed_mode = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_hold got=%b exp=1", err); end
        clear_to_op1();
        enter_seq(16'hFFFF, 16'h0001, 16'h0000);
        checks++; if (flags !== 4'b0110 || err !== 1'b0) begin failures++; $display("FAIL carry_v got=%b/%b exp=0110/0", flags, err); end
        clear_to_op1();
    endtask

    task automatic test_sub_overflow();
        signed_mode = 1'b1;
        enter_seq(16'h7FFF, 16'hFFFF, 16'h0001);
        checks++; if (result !== 16'h8000 || flags !== 4'b1011 || err !== 1'b1) begin failures++; $display("FAIL sub_ovf got=%h/%b/%b exp=8000/1011/1", result, flags, err); end
        clear_to_op1();
    endtask

    typedef struct {
        logic [15:0] opc;
        logic [15:0] res;
        logic [3:0]  flg;
    } op_vec_t;

    task automatic test_logic_ops();
        op_vec_t vecs[6];
        vecs[0] = '{16'd2, 16'h0FFF, 4'b0000};  // OR
        vecs[1] = '{16'd3, 16'h0000, 4'b0100};  // AND
        vecs[2] = '{16'd4, 16'h0FFF, 4'b0000};  // XOR
        vecs[3] = '{16'd7, 16'h00F0, 4'b0000};  // PASS
        vecs[4] = '{16'd6, 16'h0000, 4'b0100};  // SHR by 15
        vecs[5] = '{16'd5, 16'h0000, 4'b0100};  // SHL by 15, bit 1 out = 0
        press(1'b1, 1'b0, 16'h00F0);
        press(1'b1, 1'b0, 16'h0F0F);
        for (int i = 0; i < 6; i++) begin
            press(1'b1, 1'b0, vecs[i].opc);
            checks++; if (result !== vecs[i].res || flags !== vecs[i].flg) begin failures++; $display("FAIL logic_op%0d got=%h/%b exp=%h/%b", vecs[i].opc, result, flags, vecs[i].res, vecs[i].flg); end
            press(1'b0, 1'b1, 16'h0000);
            checks++; if (state !== 2'd2 || res_valid !== 1'b0 || result !== 16'h0) begin failures++; $display("FAIL res_back%0d got=%0d/%b/%h exp=2/0/0000", i, state, res_valid, result); end
        end
        press(1'b0, 1'b1, 16'h0000);
        press(1'b0, 1'b1, 16'h0000);
        checks++; if (state !== 2'd0 || op1 !== 16'h00F0) begin failures++; $display("FAIL back_keep got=%0d/%h exp=0/00F0", state, op1); end
    endtask

    task automatic test_shift_carry();
        signed_mode = 1'b0;
        enter_seq(16'h8001, 16'h0001, 16'h0005);
        checks++; if (result !== 16'h0002 || flags !== 4'b0010 || err !== 1'b1) begin failures++; $display("FAIL shl_carry got=%h/%b/%b exp=0002/0010/1", result, flags, err); end
        clear_to_op1();
        enter_seq(16'h8000, 16'h000F, 16'h0006);
        checks++; if (result !== 16'h0001 || flags !== 4'b0000 || err !== 1'b0) begin failures++; $display("FAIL shr_15 got=%h/%b/%b exp=0001/0000/0", result, flags, err); end
        clear_to_op1();
    endtask

    task automatic test_chain();
        enter_seq(16'h0004, 16'h0002, 16'h0005);
        checks++; if (result !== 16'h0010 || flags !== 4'b0000) begin failures++; $display("FAIL chain_shl got=%h/%b exp=0010/0000", result, flags); end
        chain = 1'b1;
        press(1'b1, 1'b0, 16'h0000);
        chain = 1'b0;
        checks++; if (state !== 2'd1 || op1 !== 16'h0010 || op2 !== 16'h0 || res_valid !== 1'b0 || result !== 16'h0) begin failures++; $display("FAIL chain_enter got=%0d/%h/%h/%b/%h exp=1/0010/0000/0/0000", state, op1, op2, res_valid, result); end
        press(1'b1, 1'b0, 16'h0010);
        press(1'b1, 1'b0, 16'h0004);
        checks++; if (state !== 2'd3 || result !== 16'h0000 || flags !== 4'b0100) begin failures++; $display("FAIL chain_xor got=%0d/%h/%b exp=3/0000/0100", state, result, flags); end
        clear_to_op1();
    endtask

    task automatic test_back_simul();
        press(1'b0, 1'b1, 16'h0000);
        checks++; if (state !== 2'd0) begin failures++; $display("FAIL back_op1 got=%0d exp=0", state); end
        @(negedge clk); sw = 16'hABCD;
        repeat (2) @(negedge clk);
        checks++; if (op1 !== 16'h0000 || result !== 16'h0000) begin failures++; $display("FAIL sw_idle got=%h/%h exp=0000/0000", op1, result); end
        enter_seq(16'h0009, 16'h0002, 16'h0004);
        checks++; if (result !== 16'h000B || opcode !== 3'd4) begin failures++; $display("FAIL xor_pre got=%h/%0d exp=000B/4", result, opcode); end
        press(1'b0, 1'b1, 16'h0000);
        press(1'b1, 1'b1, 16'h0003);
        checks++; if (state !== 2'd1 || opcode !== 3'd4 || res_valid !== 1'b0) begin failures++; $display("FAIL simul got=%0d/%0d/%b exp=1/4/0", state, opcode, res_valid); end
        press(1'b0, 1'b1, 16'h0000);
    endtask

    task automatic test_async_reset();
        enter_seq(16'h1234, 16'h0000, 16'h0007);
        checks++; if (result !== 16'h1234 || state !== 2'd3) begin failures++; $display("FAIL pre_rst got=%h/%0d exp=1234/3", result, state); end
        @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        checks++; if (state !== 2'd0 || result !== 16'h0 || op1 !== 16'h0 || op2 !== 16'h0 || opcode !== 3'd0) begin failures++; $display("FAIL async_rst got=%0d/%h/%h/%h/%0d exp=0/0/0/0/0", state, result, op1, op2, opcode); end
        checks++; if (flags !== 4'h0 || err !== 1'b0 || res_valid !== 1'b0) begin failures++; $display("FAIL async_rst_fl got=%b/%b/%b exp=0000/0/0", flags, err, res_valid); end
        release_reset();
        enter_seq(16'h0002, 16'h0003, 16'h0000);
        checks++; if (state !== 2'd3 || result !== 16'h0005 || res_valid !== 1'b1) begin failures++; $display("FAIL post_rst got=%0d/%h/%b exp=3/0005/1", state, result, res_valid); end
    endtask

    initial begin
        test_reset();
        test_add_basic();
        test_add_carry();
        test_sub_overflow();
        test_logic_ops();
        test_shift_carry();
        test_chain();
        test_back_simul();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
Parametrised operand-entry sequencer and registered ALU for the board-level calculator. It walks the user through OP1 -> OP2 -> OPCODE -> RESULT with debounced button pulses and latches operands from the switches. It computes a registered result with N/Z/C/V flags and an error flag. A chain mode feeds the result back as the next OP1. It sits between the PB debouncers and the display/LED drivers, and replaces the separate FSM, operand bank and combinational ALU.

Parameters:
WIDTH, 16, operand/result width in bits (4..32)
OPW, 3, opcode width; opcodes 0..7 are defined, and OPW must be >= 3
SHW, $clog2(WIDTH), shift-amount bits taken from op2 LSBs

Ports:
CLK100MHZ  in  1  system clock, 100 MHz
CPU_RESETN  in  1  asynchronous active-low reset
enter_p  in  1  one-cycle pulse from debouncer, advance/commit
back_p  in  1  one-cycle pulse from debouncer, step back one stage
chain  in  1  level; when sampled high with enter_p in RESULT, chain result into OP1
signed_mode  in  1  level; selects the error source: 1 = V, 0 = C
sw  in  WIDTH  switch data for operand/opcode entry
op1  out  WIDTH  latched operand 1
op2  out  WIDTH  latched operand 2
opcode  out  OPW  latched opcode
result  out  WIDTH  registered ALU result
flags  out  4  {N,Z,C,V}, registered with result
err  out  1  registered error flag
res_valid  out  1  high while result/flags are valid
state  out  2  0=OP1, 1=OP2, 2=OPC, 3=RES

Behaviour:
- Reset (async assert when CPU_RESETN=0, sync release): state=OP1; op1, op2, opcode, result, flags, err and res_valid are all 0.
- All state and register updates occur on the CLK100MHZ rising edge.
- OP1 state:
  - enter_p: op1<=sw, go to OP2.
  - back_p: no effect.
- OP2 state:
  - enter_p: op2<=sw, go to OPC.
  - back_p: go to OP1; op1 is kept.
- OPC state:
  - enter_p: opcode<=sw[OPW-1:0]; result, flags and err are computed from op1/op2/sw-opcode and registered in the same edge; go to RES; res_valid<=1.
  - back_p: go to OP2.
- RES state:
  - enter_p with chain=1: op1<=result; op2<=0; go to OP2.
  - enter_p with chain=0: op1, op2 and opcode are cleared; go to OP1.
  - back_p: go to OPC.
  - Leaving RES by either path clears res_valid, result, flags and err in the same edge.
- Simultaneous enter_p and back_p: back_p wins; enter_p is ignored.
- Latency: the result is visible the cycle after the committing enter_p edge. There is no combinational path from sw to result.
- Opcodes (unsigned WIDTH-bit wrap):
  - 0 ADD: op1+op2.
  - 1 SUB: op1-op2.
  - 2 OR, 3 AND, 4 XOR.
  - 5 SHL: op1 << op2[SHW-1:0].
  - 6 SHR: logical, op1 >> op2[SHW-1:0].
  - 7 PASS: op1.
  - Opcode values >7 (OPW>3) produce result=0 and err=1.
- Flags:
  - N = result[WIDTH-1].
  - Z = (result==0).
  - C: ADD carry-out of bit WIDTH-1; SUB borrow (1 iff op1<op2 unsigned); SHL last bit shifted out (0 when amount=0); all others 0.
  - V: signed overflow for ADD/SUB only; all others 0.
- err = signed_mode ? V : C, sampled at the commit edge. err is not re-evaluated if signed_mode changes while in RES.
- Changes on sw outside commit edges have no effect on any output.

Test Plan:
- Reset, then enter sw=0x0005, enter sw=0x0003, enter sw=0 (ADD) -> state 0,1,2,3 in sequence; result=0x0008, flags=0000, err=0, res_valid=1 one cycle after the third pulse.
- WIDTH=16: op1=0xFFFF, op2=0x0001, ADD, signed_mode=0 -> result=0x0000, flags N=0 Z=1 C=1 V=0, err=1. Repeat with signed_mode=1 -> err=0.
- op1=0x7FFF, op2=0xFFFF, SUB, signed_mode=1 -> result=0x8000, N=1, C=1, V=1, err=1.
- Chain: 0x0004 SHL op2=0x0002 -> result 0x0010; enter with chain=1 -> state=1, op1=0x0010, op2=0, res_valid=0; then op2=0x0010, XOR -> result 0x0000, Z=1.
- Back/simultaneous: in OPC assert enter_p and back_p in the same cycle -> state=OP2, opcode unchanged, res_valid=0; back_p in OP1 -> state stays 0.
- Assert CPU_RESETN=0 mid-cycle while in RES with result=0x1234 -> all outputs 0 and state=0 immediately, without waiting for a clock edge; subsequent entry works normally.
